riscv_core_rob_retire: RTL and testbench
========================================

Name: riscv_core_rob_retire

Overview:
- Retire-side companion to the 16-entry reorder buffer.
- Captures result data when the ROB is filled and, in ROB order, drains it to the architectural register file when the ROB asserts commit.
- Keeps a per-register in-flight scoreboard, built from ROB allocations and commits, for issue-stage hazard checks.
- Keeps a retired-instruction counter.

Parameters:
ROB_SIZE, 16, number of ROB slots; slot index width is 4
DATA_W, 32, result data width
CNT_W, 5, width of per-register in-flight counter (holds 0..ROB_SIZE)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
alloc_val  input  1  ROB allocation request valid
alloc_rdy  input  1  ROB allocation ready (allocation fires when alloc_val && alloc_rdy)
alloc_preg  input  5  destination register of allocated instruction
fill_val  input  1  result writeback valid
fill_slot  input  4  ROB slot being filled
fill_data  input  DATA_W  result value
commit_wen  input  1  ROB head commits this cycle
commit_slot  input  4  slot being committed
commit_waddr  input  5  destination register of committing slot
rf_wen  output  1  register file write enable
rf_waddr  output  5  register file write address
rf_wdata  output  DATA_W  register file write data
busy  output  32  bit r set when register r has at least one uncommitted writer
instret  output  32  count of committed instructions
err  output  1  sticky protocol error flag

Behaviour:
- Reset (async): rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, instret=0, err=0. All in-flight counters are 0; all slot data-valid bits are 0. Data array contents are don't-care.
- Fill: when fill_val, data[fill_slot] <= fill_data and dvalid[fill_slot] <= 1 at the clock edge.
- Commit, 1-cycle latency: when commit_wen, the registered outputs next cycle are rf_wen=1, rf_waddr=commit_waddr, rf_wdata=source data.
  - Source data is fill_data if fill_val && fill_slot==commit_slot in the same cycle (bypass); otherwise data[commit_slot].
  - dvalid[commit_slot] <= 0.
  - If commit_waddr==0: rf_wen=0 the next cycle, but the commit still counts toward instret and still releases the slot.
  - With no commit, rf_wen=0 next cycle; rf_waddr and rf_wdata hold their values.
- Unfilled commit: commit with dvalid[commit_slot]==0 and no same-cycle bypass sets err=1. The write is still performed with the stale data.
- Fill/commit ordering on the same slot in the same cycle: the commit consumes the fill, and dvalid ends at 0.
- Scoreboard: 32 counters of CNT_W bits, one per register r.
  - Alloc fires with alloc_preg==r: counter r increments.
  - commit_wen with commit_waddr==r: counter r decrements.
  - Both in the same cycle for the same r: counter unchanged.
  - Register 0 is never tracked; busy[0] is always 0.
  - busy[r] = (count[r] != 0), combinational from counter state. It therefore updates the cycle after the alloc/commit edge.
- Counter bounds:
  - Decrement at 0 (without a matching same-cycle increment): counter holds 0, err=1.
  - Increment at ROB_SIZE: counter saturates, err=1.
- instret increments by 1 on every commit_wen (including waddr 0) and wraps modulo 2^32.
- err clears only on reset.
- Reset mid-operation: all in-flight state discarded immediately; no rf write is issued after reset asserts.

Test Plan:
- Reset -> rf_wen=0, busy=0, instret=0, err=0. Then alloc preg 5 -> busy=0x00000020 next cycle. Fill slot 0 with 0xDEADBEEF, then commit slot 0 waddr 5 -> one cycle later rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; busy=0; instret=1.
- Same-cycle fill and commit of slot 3 (fill_data 0x12345678, waddr 7) -> next cycle rf_wdata=0x12345678, err=0; a later commit of slot 3 without refill sets err=1.
- Alloc preg 9 three times, then a cycle with simultaneous alloc preg 9 and commit waddr 9 -> busy[9] stays 1; three further commits -> busy[9]=0 exactly after the third.
- Commit with waddr 0 after filling slot 1 -> rf_wen stays 0, instret increments, busy[0] never asserts even after alloc preg 0.
- Commit waddr 4 with counter[4]=0 -> err=1 and sticky across 10 idle cycles; assert reset mid-stream with pending commits -> all outputs return to reset values, no rf_wen pulse.
- 16 allocs to preg 2 then a 17th alloc -> err=1. Wrap test: preload instret via 2^32 commits (or force) -> wraps to 0.

Source files
------------

// File: rtl/riscv_core_rob_retire.sv
// Retire-side companion to the reorder buffer. It holds slot result data, drains committed
// results to the register file and keeps a per-register in-flight scoreboard.
module riscv_core_rob_retire #(
  parameter int ROB_SIZE = 16,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_val,
  input  logic              alloc_rdy,
  input  logic [4:0]        alloc_preg,
  input  logic              fill_val,
  input  logic [3:0]        fill_slot,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              commit_wen,
  input  logic [3:0]        commit_slot,
  input  logic [4:0]        commit_waddr,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       busy,
  output logic [31:0]       instret,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROB_SIZE);

  logic [DATA_W-1:0] data_mem [ROB_SIZE];
  logic [ROB_SIZE-1:0] dvalid;
  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;
  logic cnt_err;
  logic alloc_fire;
  logic bypass;
  logic unfilled;
  logic [DATA_W-1:0] src_data;

  // A same-cycle fill of the committing slot is forwarded straight to the write port.
  always_comb begin
    alloc_fire = alloc_val && alloc_rdy;
    bypass     = fill_val && (fill_slot == commit_slot);
    src_data   = bypass ? fill_data : data_mem[commit_slot];
    unfilled   = commit_wen && !bypass && !dvalid[commit_slot];
  end

  always_ff @(posedge clk) begin
    if (fill_val)
      data_mem[fill_slot] <= fill_data;
  end

  // Commit is applied after fill so a same-slot fill+commit leaves the slot empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvalid <= '0;
    end else begin
      if (fill_val)
        dvalid[fill_slot] <= 1'b1;
      if (commit_wen)
        dvalid[commit_slot] <= 1'b0;
    end
  end

  always_comb begin
    inc_vec = alloc_fire ? (32'd1 << alloc_preg) : 32'd0;
    dec_vec = commit_wen ? (32'd1 << commit_waddr) : 32'd0;
    cnt_err = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_next[r] = cnt[r];
      if (r != 0) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          if (cnt[r] == CNT_MAX)
            cnt_err = 1'b1;
          else
            cnt_next[r] = cnt[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0)
            cnt_err = 1'b1;
          else
            cnt_next[r] = cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= cnt_next[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++)
      busy[r] = (cnt[r] != '0);
  end

  // Register 0 commits still retire and count, they just never write the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      instret  <= '0;
      err      <= 1'b0;
    end else begin
      rf_wen <= commit_wen && (commit_waddr != 5'd0);
      if (commit_wen) begin
        rf_waddr <= commit_waddr;
        rf_wdata <= src_data;
        instret  <= instret + 32'd1;
      end
      if (unfilled || cnt_err)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core_rob_retire.sv
// Directed bench for riscv_core_rob_retire: one task per scenario, each checks its own
// hand-computed expectations.
module tb_riscv_core_rob_retire;

  logic        clk;
  logic        reset;
  logic        alloc_val;
  logic        alloc_rdy;
  logic [4:0]  alloc_preg;
  logic        fill_val;
  logic [3:0]  fill_slot;
  logic [31:0] fill_data;
  logic        commit_wen;
  logic [3:0]  commit_slot;
  logic [4:0]  commit_waddr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic [31:0] instret;
  logic        err;

  int n_cmp;
  int n_bad;

  riscv_core_rob_retire dut (
    .clk(clk), .reset(reset),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_preg(alloc_preg),
    .fill_val(fill_val), .fill_slot(fill_slot), .fill_data(fill_data),
    .commit_wen(commit_wen), .commit_slot(commit_slot), .commit_waddr(commit_waddr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .instret(instret), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_val    = 1'b0;
    alloc_rdy    = 1'b1;
    alloc_preg   = '0;
    fill_val     = 1'b0;
    fill_slot    = '0;
    fill_data    = '0;
    commit_wen   = 1'b0;
    commit_slot  = '0;
    commit_waddr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rf_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_busy: got %h want 0", busy); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_instret: got %0d want 0", instret); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_basic();
    do_reset();
    alloc_val = 1'b1; alloc_rdy = 1'b0; alloc_preg = 5'd3;
    step();
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("[TB] FAIL alloc_not_ready: got %h want 0", busy); end
    alloc_rdy = 1'b1; alloc_preg = 5'd5;
    step();
    alloc_val = 1'b0;
    n_cmp++; if (busy !== 32'h0000_0020) begin n_bad++; $display("[TB] FAIL alloc_busy5: got %h want 00000020", busy); end
    fill_val = 1'b1; fill_slot = 4'd0; fill_data = 32'hDEAD_BEEF;
    step();
    fill_val = 1'b0;
    commit_wen = 1'b1; commit_slot = 4'd0; commit_waddr = 5'd5;
    step();
    commit_wen = 1'b0;
    n_cmp++; if (rf_wen !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_rf_wen: got %0b want 1", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_bad++; $display("[TB] FAIL basic_rf_waddr: got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("[TB] FAIL basic_rf_wdata: got %h want deadbeef", rf_wdata); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("[TB] FAIL basic_busy: got %h want 0", busy); end
    n_cmp++; if (instret !== 32'd1) begin n_bad++; $display("[TB] FAIL basic_instret: got %0d want 1", instret); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_err: got %0b want 0", err); end
    step();
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_idle_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("[TB] FAIL basic_hold_wdata: got %h want deadbeef", rf_wdata); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_val = 1'b1; alloc_preg = 5'd7;
    step();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd3; fill_data = 32'h1234_5678;
    commit_wen = 1'b1; commit_slot = 4'd3; commit_waddr = 5'd7;
    step();
    fill_val = 1'b0; commit_wen = 1'b0;
    n_cmp++; if (rf_wdata !== 32'h1234_5678) begin n_bad++; $display("[TB] FAIL bypass_wdata: got %h want 12345678", rf_wdata); end
    n_cmp++; if (rf_waddr !== 5'd7) begin n_bad++; $display("[TB] FAIL bypass_waddr: got %0d want 7", rf_waddr); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL bypass_err: got %0b want 0", err); end
    step();
    n_cmp++; if (rf_waddr !== 5'd7) begin n_bad++; $display("[TB] FAIL bypass_hold_waddr: got %0d want 7", rf_waddr); end
    alloc_val = 1'b1; alloc_preg = 5'd7;
    step();
    alloc_val = 1'b0;
    commit_wen = 1'b1; commit_slot = 4'd3; commit_waddr = 5'd7;
    step();
    commit_wen = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL unfilled_err: got %0b want 1", err); end
    n_cmp++; if (rf_wen !== 1'b1) begin n_bad++; $display("[TB] FAIL unfilled_wen: got %0b want 1", rf_wen); end
    n_cmp++; if (rf_wdata !== 32'h1234_5678) begin n_bad++; $display("[TB] FAIL unfilled_stale: got %h want 12345678", rf_wdata); end
    n_cmp++; if (instret !== 32'd2) begin n_bad++; $display("[TB] FAIL bypass_instret: got %0d want 2", instret); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] exp_busy;
    do_reset();
    alloc_val = 1'b1; alloc_preg = 5'd9;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (busy !== 32'h0000_0200) begin n_bad++; $display("[TB] FAIL sb_after_allocs: got %h want 00000200", busy); end
    fill_val = 1'b1; fill_slot = 4'd4; fill_data = 32'h0000_0099;
    commit_wen = 1'b1; commit_slot = 4'd4; commit_waddr = 5'd9;
    step();
    alloc_val = 1'b0;
    n_cmp++; if (busy !== 32'h0000_0200) begin n_bad++; $display("[TB] FAIL sb_same_cycle: got %h want 00000200", busy); end
    n_cmp++; if (rf_wdata !== 32'h0000_0099) begin n_bad++; $display("[TB] FAIL sb_wdata: got %h want 00000099", rf_wdata); end
    for (int i = 0; i < 3; i++) begin
      fill_data = 32'(i);
      step();
      exp_busy = (i < 2) ? 32'h0000_0200 : 32'd0;
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("[TB] FAIL sb_drain%0d: got %h want %h", i, busy, exp_busy); end
    end
    fill_val = 1'b0; commit_wen = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL sb_err: got %0b want 0", err); end
    n_cmp++; if (instret !== 32'd4) begin n_bad++; $display("[TB] FAIL sb_instret: got %0d want 4", instret); end
  endtask

  task automatic test_waddr0();
    do_reset();
    fill_val = 1'b1; fill_slot = 4'd1; fill_data = 32'hA5A5_A5A5;
    step();
    fill_val = 1'b0;
    commit_wen = 1'b1; commit_slot = 4'd1; commit_waddr = 5'd0;
    step();
    commit_wen = 1'b0;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL w0_rf_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (instret !== 32'd1) begin n_bad++; $display("[TB] FAIL w0_instret: got %0d want 1", instret); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL w0_err: got %0b want 0", err); end
    alloc_val = 1'b1; alloc_preg = 5'd0;
    step();
    alloc_val = 1'b0;
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("[TB] FAIL w0_busy: got %h want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL w0_alloc_err: got %0b want 0", err); end
  endtask

  task automatic test_err_sticky();
    do_reset();
    fill_val = 1'b1; fill_slot = 4'd2; fill_data = 32'h0000_0044;
    commit_wen = 1'b1; commit_slot = 4'd2; commit_waddr = 5'd4;
    step();
    fill_val = 1'b0; commit_wen = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL underflow_err: got %0b want 1", err); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("[TB] FAIL underflow_busy: got %h want 0", busy); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL sticky_err%0d: got %0b want 1", i, err); end
    end
    alloc_val = 1'b1; alloc_preg = 5'd6;
    step();
    alloc_val = 1'b0;
    fill_val = 1'b1; fill_slot = 4'd5; fill_data = 32'h0000_0055;
    step();
    fill_val = 1'b0;
    commit_wen = 1'b1; commit_slot = 4'd5; commit_waddr = 5'd6;
    reset = 1'b1;
    #1;
    n_cmp++; if (instret !== 32'd0 || err !== 1'b0 || busy !== 32'd0) begin
      n_bad++; $display("[TB] FAIL async_reset: got instret=%0d err=%0b busy=%h want 0/0/0", instret, err, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
        n_bad++; $display("[TB] FAIL midreset_rf%0d: got wen=%0b waddr=%0d wdata=%h want 0/0/0", i, rf_wen, rf_waddr, rf_wdata);
      end
    end
    commit_wen = 1'b0;
    reset = 1'b0;
    step();
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL postreset_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("[TB] FAIL postreset_instret: got %0d want 0", instret); end
  endtask

  task automatic test_saturate();
    logic [31:0] exp_busy;
    do_reset();
    alloc_val = 1'b1; alloc_preg = 5'd2;
    for (int i = 0; i < 16; i++) step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL sat16_err: got %0b want 0", err); end
    n_cmp++; if (busy !== 32'h0000_0004) begin n_bad++; $display("[TB] FAIL sat16_busy: got %h want 00000004", busy); end
    step();
    alloc_val = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL sat17_err: got %0b want 1", err); end
    fill_val = 1'b1; fill_slot = 4'd6; fill_data = 32'h0000_0022;
    commit_wen = 1'b1; commit_slot = 4'd6; commit_waddr = 5'd2;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_busy = (i < 15) ? 32'h0000_0004 : 32'd0;
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("[TB] FAIL sat_drain%0d: got %h want %h", i, busy, exp_busy); end
    end
    fill_val = 1'b0; commit_wen = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.instret = 32'hFFFF_FFFE;
    #1;
    release dut.instret;
    fill_val = 1'b1; fill_slot = 4'd7; fill_data = 32'h0000_0077;
    commit_wen = 1'b1; commit_slot = 4'd7; commit_waddr = 5'd0;
    step();
    n_cmp++; if (instret !== 32'hFFFF_FFFF) begin n_bad++; $display("[TB] FAIL wrap_max: got %h want ffffffff", instret); end
    step();
    fill_val = 1'b0; commit_wen = 1'b0;
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("[TB] FAIL wrap_zero: got %h want 0", instret); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_waddr0();
    test_err_sticky();
    test_saturate();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
